// File: rtl/controle_varredura_pkg.sv
// Shared state encoding and default parameter constants for the turret sweep controller.
// Latency: n/a (types and constants only). Backpressure: n/a.
package controle_varredura_pkg;

    localparam int M_PADRAO         = 100;
    localparam int N_PADRAO         = 7;
    localparam int T_ESPERA_PADRAO  = 50;
    localparam int T_TIMEOUT_PADRAO = 1000;
    localparam int W_PADRAO         = 10;

    typedef enum logic [3:0] {
        INICIAL = 4'd0,
        ESPERA  = 4'd1,
        MEDE    = 4'd2,
        AGUARDA = 4'd3,
        PASSO   = 4'd4,
        TRAVADO = 4'd5
    } estado_t;

endpackage

// File: rtl/contador_soma_sub_m.sv
// Saturating up/down counter over [0, M-1] with async and sync clear.
// Latency: q updates on the edge after soma/sub/zera_s. Backpressure: none, saturates at the ends.
module contador_soma_sub_m #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic         clock,
    input  logic         zera_as,
    input  logic         zera_s,
    input  logic         soma,
    input  logic         sub,
    output logic [N-1:0] q
);

    localparam logic [N-1:0] MAXIMO = N'(M - 1);

    always_ff @(posedge clock or posedge zera_as) begin
        if (zera_as) begin
            q <= '0;
        end else if (zera_s) begin
            q <= '0;
        end else if (soma && !sub && (q != MAXIMO)) begin
            q <= q + N'(1);
        end else if (sub && !soma && (q != '0)) begin
            q <= q - N'(1);
        end
    end

endmodule

// File: rtl/controle_varredura.sv
// Turret sweep FSM: dwell, measure, step/reverse at end stops; TRAVA_ALVO_EN adds target lock (TRAVADO).
// Latency: all outputs registered, one edge after the deciding condition. Backpressure: waits for medir_pronto up to T_TIMEOUT cycles.
module controle_varredura
    import controle_varredura_pkg::*;
#(
    parameter int M         = M_PADRAO,
    parameter int N         = N_PADRAO,
    parameter int T_ESPERA  = T_ESPERA_PADRAO,
    parameter int T_TIMEOUT = T_TIMEOUT_PADRAO,
    parameter int W         = W_PADRAO
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic         ligar,
    input  logic         medir_pronto,
    input  logic         detectado,
    output logic         medir,
    output logic [N-1:0] posicao,
    output logic         direcao,
    output logic         alvo,
    output logic         erro,
    output logic         fim_varredura,
    output logic [3:0]   db_estado
);

    localparam logic [N-1:0] POS_MAX     = N'(M - 1);
    localparam logic [W-1:0] FIM_ESPERA  = W'(T_ESPERA - 1);
    localparam logic [W-1:0] FIM_TIMEOUT = W'(T_TIMEOUT - 1);

    estado_t        estado;
    logic [W-1:0]   timer;
    logic           reverte_cima;
    logic           reverte_baixo;
    logic           sobe;
    logic           passo_ativo;
`ifdef TRAVA_ALVO_EN
    logic           aguarda_resp;
`endif

    // A step suppressed by ligar=0 keeps the counter consistent with the forced INICIAL.
    always_comb begin
        reverte_cima  = direcao && (posicao == POS_MAX);
        reverte_baixo = !direcao && (posicao == '0);
        sobe          = direcao ? !reverte_cima : reverte_baixo;
        passo_ativo   = (estado == PASSO) && ligar;
    end

    contador_soma_sub_m #(
        .M(M),
        .N(N)
    ) u_posicao (
        .clock   (clock),
        .zera_as (~zera_as_n),
        .zera_s  (estado == INICIAL),
        .soma    (passo_ativo && sobe),
        .sub     (passo_ativo && !sobe),
        .q       (posicao)
    );

    assign db_estado = estado;

    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado        <= INICIAL;
            timer         <= '0;
            direcao       <= 1'b1;
            medir         <= 1'b0;
            alvo          <= 1'b0;
            erro          <= 1'b0;
            fim_varredura <= 1'b0;
`ifdef TRAVA_ALVO_EN
            aguarda_resp  <= 1'b0;
`endif
        end else begin
            medir         <= 1'b0;
            alvo          <= 1'b0;
            erro          <= 1'b0;
            fim_varredura <= 1'b0;
            if (!ligar) begin
                estado  <= INICIAL;
                timer   <= '0;
                direcao <= 1'b1;
`ifdef TRAVA_ALVO_EN
                aguarda_resp <= 1'b0;
`endif
            end else begin
                case (estado)
                    INICIAL: begin
                        timer   <= '0;
                        direcao <= 1'b1;
                        estado  <= ESPERA;
                    end
                    ESPERA: begin
                        if (timer == FIM_ESPERA) begin
                            timer  <= '0;
                            medir  <= 1'b1;
                            estado <= MEDE;
                        end else begin
                            timer <= timer + W'(1);
                        end
                    end
                    MEDE: begin
                        timer  <= '0;
                        estado <= AGUARDA;
                    end
                    AGUARDA: begin
                        // A response arriving in the timeout cycle takes priority over erro.
                        if (medir_pronto) begin
                            timer <= '0;
                            if (detectado) begin
                                alvo   <= 1'b1;
`ifdef TRAVA_ALVO_EN
                                estado <= TRAVADO;
`else
                                estado <= PASSO;
`endif
                            end else begin
                                estado <= PASSO;
                            end
                        end else if (timer == FIM_TIMEOUT) begin
                            timer  <= '0;
                            erro   <= 1'b1;
                            estado <= PASSO;
                        end else begin
                            timer <= timer + W'(1);
                        end
                    end
                    PASSO: begin
                        timer  <= '0;
                        estado <= ESPERA;
                        if (reverte_cima) begin
                            direcao       <= 1'b0;
                            fim_varredura <= 1'b1;
                        end else if (reverte_baixo) begin
                            direcao       <= 1'b1;
                            fim_varredura <= 1'b1;
                        end
                    end
`ifdef TRAVA_ALVO_EN
                    // Locked: alternate a dwell and a response wait without moving the turret.
                    TRAVADO: begin
                        if (!aguarda_resp) begin
                            if (timer == FIM_ESPERA) begin
                                timer        <= '0;
                                medir        <= 1'b1;
                                aguarda_resp <= 1'b1;
                            end else begin
                                timer <= timer + W'(1);
                            end
                        end else if (medir_pronto) begin
                            timer        <= '0;
                            aguarda_resp <= 1'b0;
                            if (!detectado) begin
                                estado <= PASSO;
                            end
                        end else if (timer == FIM_TIMEOUT) begin
                            timer        <= '0;
                            aguarda_resp <= 1'b0;
                            erro         <= 1'b1;
                            estado       <= PASSO;
                        end else begin
                            timer <= timer + W'(1);
                        end
                    end
`endif
                    default: begin
                        timer  <= '0;
                        estado <= INICIAL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controle_varredura.sv
// Directed bench for controle_varredura with M=4, T_ESPERA=3, T_TIMEOUT=8 and a delayed-response sensor model.
module tb_controle_varredura;

    localparam int M  = 4;
    localparam int N  = 3;
    localparam int TE = 3;
    localparam int TT = 8;
    localparam int W  = 10;

    logic         clock = 1'b0;
    logic         zera_as_n;
    logic         ligar;
    logic         medir_pronto = 1'b0;
    logic         detectado = 1'b0;
    logic         medir;
    logic [N-1:0] posicao;
    logic         direcao;
    logic         alvo;
    logic         erro;
    logic         fim_varredura;
    logic [3:0]   db_estado;

    int   checks = 0;
    int   errors = 0;
    int   sensor_atraso = 2;
    logic sensor_det = 1'b0;
    int   sensor_cnt = 0;

    always #5 clock = ~clock;

    controle_varredura #(
        .M(M), .N(N), .T_ESPERA(TE), .T_TIMEOUT(TT), .W(W)
    ) dut (
        .clock         (clock),
        .zera_as_n     (zera_as_n),
        .ligar         (ligar),
        .medir_pronto  (medir_pronto),
        .detectado     (detectado),
        .medir         (medir),
        .posicao       (posicao),
        .direcao       (direcao),
        .alvo          (alvo),
        .erro          (erro),
        .fim_varredura (fim_varredura),
        .db_estado     (db_estado)
    );

    // Sensor: answers sensor_atraso cycles after seeing medir (0 = never answers).
    always @(negedge clock) begin
        medir_pronto = 1'b0;
        detectado    = 1'b0;
        if (medir === 1'b1 && sensor_atraso > 0) begin
            sensor_cnt = sensor_atraso;
        end else if (sensor_cnt > 0) begin
            sensor_cnt = sensor_cnt - 1;
            if (sensor_cnt == 0) begin
                medir_pronto = 1'b1;
                detectado    = sensor_det;
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic reiniciar(input int atraso, input logic det);
        ligar         = 1'b0;
        sensor_atraso = atraso;
        sensor_det    = det;
        repeat (10) tick();
        ligar = 1'b1;
    endtask

    task automatic proximo_medir(output int ciclos, output int alvos, output int erros,
                                 output int fims, output logic [N-1:0] pos_fim);
        ciclos  = -1;
        alvos   = 0;
        erros   = 0;
        fims    = 0;
        pos_fim = '0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (alvo === 1'b1) alvos++;
            if (erro === 1'b1) erros++;
            if (fim_varredura === 1'b1) begin
                fims++;
                pos_fim = posicao;
            end
            if (medir === 1'b1) begin
                ciclos = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        zera_as_n = 1'b0;
        ligar     = 1'b0;
        #12;
        checks++;
        if (posicao !== 3'd0) begin errors++; $display("FAIL reset_posicao: got %0d expected 0", posicao); end
        checks++;
        if (direcao !== 1'b1) begin errors++; $display("FAIL reset_direcao: got %0b expected 1", direcao); end
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", db_estado); end
        checks++;
        if ({medir, alvo, erro, fim_varredura} !== 4'b0000)
            begin errors++; $display("FAIL reset_pulsos: got %b expected 0000", {medir, alvo, erro, fim_varredura}); end
        zera_as_n = 1'b1;
        tick();
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL desligado_estado: got %0d expected 0", db_estado); end
    endtask

    task automatic test_varredura;
        logic [N-1:0] esperado [8];
        int c, a, e, f;
        logic [N-1:0] pf;
        esperado = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
        reiniciar(2, 1'b0);
        for (int i = 0; i < 8; i++) begin
            proximo_medir(c, a, e, f, pf);
            checks++;
            if (c < 0) begin errors++; $display("FAIL varredura_medir_%0d: got timeout expected pulse", i); return; end
            checks++;
            if (posicao !== esperado[i])
                begin errors++; $display("FAIL varredura_pos_%0d: got %0d expected %0d", i, posicao, esperado[i]); end
            if (i > 0) begin
                checks++;
                if (c !== 7) begin errors++; $display("FAIL varredura_intervalo_%0d: got %0d expected 7", i, c); end
            end
            checks++;
            if (f !== ((i == 4 || i == 7) ? 1 : 0))
                begin errors++; $display("FAIL varredura_fim_%0d: got %0d expected %0d", i, f, (i == 4 || i == 7) ? 1 : 0); end
            if (i == 4 || i == 7) begin
                checks++;
                if (pf !== ((i == 4) ? 3'd2 : 3'd1))
                    begin errors++; $display("FAIL varredura_fim_pos_%0d: got %0d expected %0d", i, pf, (i == 4) ? 2 : 1); end
            end
            if (i == 4) begin
                checks++;
                if (direcao !== 1'b0) begin errors++; $display("FAIL varredura_direcao: got %0b expected 0", direcao); end
            end
        end
    endtask

    task automatic test_timeout;
        int c, a, e, f, t_erro;
        logic [N-1:0] pf;
        logic [N-1:0] pos_erro;
        reiniciar(0, 1'b0);
        proximo_medir(c, a, e, f, pf);
        checks++;
        if (c < 0) begin errors++; $display("FAIL timeout_medir: got timeout expected pulse"); return; end
        t_erro   = -1;
        pos_erro = '1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (erro === 1'b1 && t_erro < 0) begin
                t_erro   = k;
                pos_erro = posicao;
            end
        end
        checks++;
        if (t_erro !== 9) begin errors++; $display("FAIL timeout_ciclo: got %0d expected 9", t_erro); end
        checks++;
        if (pos_erro !== 3'd0) begin errors++; $display("FAIL timeout_pos_antes: got %0d expected 0", pos_erro); end
        tick();
        checks++;
        if (erro !== 1'b0) begin errors++; $display("FAIL timeout_pulso_unico: got %0b expected 0", erro); end
        checks++;
        if (posicao !== 3'd1) begin errors++; $display("FAIL timeout_passo: got %0d expected 1", posicao); end
    endtask

    task automatic test_timeout_pronto;
        int c, a, e, f, n_erro;
        logic [N-1:0] pf;
        logic [3:0]   est9;
        logic [N-1:0] pos10;
        reiniciar(8, 1'b0);
        proximo_medir(c, a, e, f, pf);
        checks++;
        if (c < 0) begin errors++; $display("FAIL pronto_medir: got timeout expected pulse"); return; end
        n_erro = 0;
        est9   = '1;
        pos10  = '1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (erro === 1'b1) n_erro++;
            if (k == 9) est9 = db_estado;
            if (k == 10) pos10 = posicao;
        end
        checks++;
        if (n_erro !== 0) begin errors++; $display("FAIL pronto_sem_erro: got %0d expected 0", n_erro); end
        checks++;
        if (est9 !== 4'd4) begin errors++; $display("FAIL pronto_estado_passo: got %0d expected 4", est9); end
        checks++;
        if (pos10 !== 3'd1) begin errors++; $display("FAIL pronto_passo: got %0d expected 1", pos10); end
    endtask

    task automatic test_alvo;
        int c, a, e, f;
        logic [N-1:0] pf;
        logic achou;
        reiniciar(2, 1'b0);
        achou = 1'b0;
        for (int i = 0; i < 4 && !achou; i++) begin
            proximo_medir(c, a, e, f, pf);
            if (c >= 0 && posicao === 3'd2) achou = 1'b1;
        end
        checks++;
        if (!achou) begin errors++; $display("FAIL alvo_chegada: got no pos 2 expected pos 2"); return; end
        sensor_det = 1'b1;
        tick();
        tick();
        checks++;
        if (alvo !== 1'b0) begin errors++; $display("FAIL alvo_cedo: got %0b expected 0", alvo); end
        tick();
        checks++;
        if (alvo !== 1'b1) begin errors++; $display("FAIL alvo_pulso: got %0b expected 1", alvo); end
`ifdef TRAVA_ALVO_EN
        checks++;
        if (db_estado !== 4'd5) begin errors++; $display("FAIL alvo_travado: got %0d expected 5", db_estado); end
`else
        checks++;
        if (db_estado !== 4'd4) begin errors++; $display("FAIL alvo_passo: got %0d expected 4", db_estado); end
`endif
        tick();
        checks++;
        if (alvo !== 1'b0) begin errors++; $display("FAIL alvo_pulso_unico: got %0b expected 0", alvo); end
`ifdef TRAVA_ALVO_EN
        checks++;
        if (posicao !== 3'd2) begin errors++; $display("FAIL trava_pos: got %0d expected 2", posicao); end
        for (int j = 0; j < 4; j++) begin
            proximo_medir(c, a, e, f, pf);
            checks++;
            if (c < 0) begin errors++; $display("FAIL trava_medir_%0d: got timeout expected pulse", j); return; end
            checks++;
            if (posicao !== 3'd2 || a !== 0 || db_estado !== 4'd5)
                begin errors++; $display("FAIL trava_mantem_%0d: got pos %0d alvos %0d estado %0d expected 2 0 5", j, posicao, a, db_estado); end
        end
        sensor_det = 1'b0;
        repeat (4) tick();
`endif
        checks++;
        if (posicao !== 3'd3) begin errors++; $display("FAIL alvo_passo_pos: got %0d expected 3", posicao); end
        checks++;
        if (db_estado !== 4'd1) begin errors++; $display("FAIL alvo_espera: got %0d expected 1", db_estado); end
        sensor_det = 1'b0;
    endtask

    task automatic test_reset_assincrono;
        int c, a, e, f;
        logic [N-1:0] pf;
        logic achou;
        reiniciar(2, 1'b0);
        achou = 1'b0;
        for (int i = 0; i < 5 && !achou; i++) begin
            proximo_medir(c, a, e, f, pf);
            if (c >= 0 && posicao === 3'd3) achou = 1'b1;
        end
        checks++;
        if (!achou) begin errors++; $display("FAIL rst_chegada: got no pos 3 expected pos 3"); return; end
        #2;
        zera_as_n = 1'b0;
        #1;
        checks++;
        if (posicao !== 3'd0) begin errors++; $display("FAIL rst_async_pos: got %0d expected 0", posicao); end
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL rst_async_estado: got %0d expected 0", db_estado); end
        checks++;
        if (medir !== 1'b0 || direcao !== 1'b1)
            begin errors++; $display("FAIL rst_async_saidas: got medir %0b dir %0b expected 0 1", medir, direcao); end
        zera_as_n = 1'b1;
        tick();
        checks++;
        if (db_estado !== 4'd1 || posicao !== 3'd0)
            begin errors++; $display("FAIL rst_retoma: got estado %0d pos %0d expected 1 0", db_estado, posicao); end
    endtask

    task automatic test_desliga;
        int c, a, e, f, pulsos;
        logic [N-1:0] pf;
        reiniciar(2, 1'b1);
        proximo_medir(c, a, e, f, pf);
        checks++;
        if (c < 0) begin errors++; $display("FAIL desliga_medir: got timeout expected pulse"); return; end
        tick();
        tick();
        checks++;
        if (db_estado !== 4'd3) begin errors++; $display("FAIL desliga_aguarda: got %0d expected 3", db_estado); end
        ligar = 1'b0;
        tick();
        checks++;
        if (db_estado !== 4'd0) begin errors++; $display("FAIL desliga_estado: got %0d expected 0", db_estado); end
        pulsos = 0;
        for (int k = 0; k < 4; k++) begin
            if (alvo === 1'b1 || erro === 1'b1) pulsos++;
            tick();
        end
        checks++;
        if (pulsos !== 0) begin errors++; $display("FAIL desliga_pulsos: got %0d expected 0", pulsos); end
        checks++;
        if (posicao !== 3'd0) begin errors++; $display("FAIL desliga_pos: got %0d expected 0", posicao); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_varredura();
        test_timeout();
        test_timeout_pronto();
        test_alvo();
        test_reset_assincrono();
        test_desliga();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
